pc_sequencer: RTL and testbench



---
 rtl/pc_pkg.sv | 19 +
 rtl/branch_target_calc.sv | 44 ++++
 rtl/pc_sequencer.sv | 124 ++++++++++++
 tb/tb_pc_sequencer.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared definitions for the fetch-address sequencer: redirect kinds, FSM
// state encoding and default field widths.
package pc_pkg;

   localparam int ADDR_W_DEF = 32;
   localparam int IMM_W_DEF  = 16;
   localparam int JIDX_W_DEF = 26;

   localparam logic [1:0] KIND_BR = 2'd0;
   localparam logic [1:0] KIND_J  = 2'd1;
   localparam logic [1:0] KIND_JR = 2'd2;

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      PEND = 2'd2
   } state_t;

endpackage

// File: rtl/branch_target_calc.sv
// Combinational redirect-target generator: branch, jump and jump-register
// targets, plus a flag for jump-register targets that are not word aligned.
module branch_target_calc
   import pc_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int IMM_W  = IMM_W_DEF,
   parameter int JIDX_W = JIDX_W_DEF
) (
   input  logic [1:0]        kind,
   input  logic [ADDR_W-1:0] redir_pc,
   input  logic [IMM_W-1:0]  imm,
   input  logic [JIDX_W-1:0] idx,
   input  logic [ADDR_W-1:0] reg_target,
   output logic [ADDR_W-1:0] target,
   output logic              misaligned
);

   logic signed [IMM_W-1:0]  imm_s;
   logic signed [ADDR_W-1:0] br_off;
   logic [ADDR_W-1:0]        seq;
   logic [ADDR_W-1:0]        br_target;
   logic [ADDR_W-1:0]        j_target;

   // Word offset is sign-extended to the full address width before scaling.
   assign imm_s     = imm;
   assign br_off    = ADDR_W'(imm_s) <<< 2;
   assign seq       = redir_pc + ADDR_W'(4);
   assign br_target = seq + ADDR_W'(br_off);
   assign j_target  = {seq[ADDR_W-1:JIDX_W+2], idx, 2'b00};

   always_comb begin
      target = seq;
      case (kind)
         KIND_BR: target = br_target;
         KIND_J:  target = j_target;
         KIND_JR: target = reg_target;
         default: target = seq;
      endcase
   end

   assign misaligned = (kind == KIND_JR) && (reg_target[1:0] != 2'b00);

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: holds the fetch PC, accepts redirects from
// decode/execute and applies them after an optional delay slot.
module pc_sequencer
   import pc_pkg::*;
#(
   parameter int              ADDR_W      = ADDR_W_DEF,
   parameter int              IMM_W       = IMM_W_DEF,
   parameter int              JIDX_W      = JIDX_W_DEF,
   parameter logic [ADDR_W-1:0] RESET_PC  = '0,
   parameter int              DELAY_SLOTS = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall,
   input  logic              redir_valid,
   output logic              redir_ready,
   input  logic [1:0]        redir_kind,
   input  logic [ADDR_W-1:0] redir_pc,
   input  logic [IMM_W-1:0]  redir_imm,
   input  logic [JIDX_W-1:0] redir_idx,
   input  logic [ADDR_W-1:0] redir_reg,
   output logic [ADDR_W-1:0] pc,
   output logic              pc_valid,
   output logic              misalign_err
);

   state_t            state, state_next;
   logic [ADDR_W-1:0] pc_q, pc_next;
   logic [ADDR_W-1:0] tgt_q;
   logic              tgt_load;
   logic              cnt_q, cnt_next;
   logic              pc_valid_q;
   logic              mis_q;

   logic [ADDR_W-1:0] target;
   logic              misaligned;
   logic              advance;
   logic              offered;
   logic              accept;

   branch_target_calc #(
      .ADDR_W (ADDR_W),
      .IMM_W  (IMM_W),
      .JIDX_W (JIDX_W)
   ) u_calc (
      .kind       (redir_kind),
      .redir_pc   (redir_pc),
      .imm        (redir_imm),
      .idx        (redir_idx),
      .reg_target (redir_reg),
      .target     (target),
      .misaligned (misaligned)
   );

   assign advance = pc_valid_q & ~stall;
   assign offered = redir_valid & redir_ready & (redir_kind != 2'd3);
   assign accept  = offered & ~misaligned;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= BOOT;
         pc_q       <= RESET_PC;
         cnt_q      <= 1'b0;
         pc_valid_q <= 1'b0;
         mis_q      <= 1'b0;
      end else begin
         state      <= state_next;
         pc_q       <= pc_next;
         cnt_q      <= cnt_next;
         pc_valid_q <= 1'b1;
         mis_q      <= offered & misaligned;
      end
   end

   // Pending target is pure data; the FSM state qualifies whether it is live.
   always_ff @(posedge clk) begin
      if (tgt_load) tgt_q <= target;
   end

   always_comb begin
      state_next = state;
      pc_next    = pc_q;
      cnt_next   = cnt_q;
      tgt_load   = 1'b0;
      case (state)
         BOOT: state_next = RUN;
         RUN: begin
            if (accept) begin
               tgt_load = 1'b1;
               if (DELAY_SLOTS == 0) begin
                  if (advance) pc_next = target;
                  else         state_next = PEND;
               end else begin
                  state_next = PEND;
                  cnt_next   = ~advance;
                  if (advance) pc_next = pc_q + ADDR_W'(4);
               end
            end else if (advance) begin
               pc_next = pc_q + ADDR_W'(4);
            end
         end
         PEND: begin
            if (advance) begin
               if (cnt_q) begin
                  pc_next  = pc_q + ADDR_W'(4);
                  cnt_next = 1'b0;
               end else begin
                  pc_next    = tgt_q;
                  state_next = RUN;
               end
            end
         end
         default: state_next = BOOT;
      endcase
   end

   always_comb begin
      redir_ready  = (state == RUN);
      pc           = pc_q;
      pc_valid     = pc_valid_q;
      misalign_err = mis_q;
   end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed scoreboard bench for pc_sequencer with one and zero delay slots.
module tb_pc_sequencer;

   localparam logic [31:0] RPC = 32'h0040_0000;
   localparam int K_BR = 0, K_J = 1, K_JR = 2, K_RSV = 3;

   typedef struct packed {
      logic [31:0] pc;
      logic        rdy;
      logic        mis;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst1 = 1'b1, stall1 = 1'b0, rv1 = 1'b0;
   logic [1:0]  kind1 = '0;
   logic [31:0] rpc1 = '0, rreg1 = '0;
   logic [15:0] imm1 = '0;
   logic [25:0] idx1 = '0;
   logic [31:0] pc1;
   logic        pcv1, rdy1, mis1;

   logic        rst0 = 1'b1, stall0 = 1'b0, rv0 = 1'b0;
   logic [1:0]  kind0 = '0;
   logic [31:0] rpc0 = '0, rreg0 = '0;
   logic [15:0] imm0 = '0;
   logic [25:0] idx0 = '0;
   logic [31:0] pc0;
   logic        pcv0, rdy0, mis0;

   int checks = 0;
   int failures = 0;
   exp_t q1[$];
   exp_t q0[$];

   pc_sequencer #(.ADDR_W(32), .IMM_W(16), .JIDX_W(26), .RESET_PC(RPC), .DELAY_SLOTS(1)) dut1 (
      .clk(clk), .rst(rst1), .stall(stall1), .redir_valid(rv1), .redir_ready(rdy1),
      .redir_kind(kind1), .redir_pc(rpc1), .redir_imm(imm1), .redir_idx(idx1),
      .redir_reg(rreg1), .pc(pc1), .pc_valid(pcv1), .misalign_err(mis1)
   );

   pc_sequencer #(.ADDR_W(32), .IMM_W(16), .JIDX_W(26), .RESET_PC(RPC), .DELAY_SLOTS(0)) dut0 (
      .clk(clk), .rst(rst0), .stall(stall0), .redir_valid(rv0), .redir_ready(rdy0),
      .redir_kind(kind0), .redir_pc(rpc0), .redir_imm(imm0), .redir_idx(idx0),
      .redir_reg(rreg0), .pc(pc0), .pc_valid(pcv0), .misalign_err(mis0)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Drives one cycle of inputs and, if push is set, queues the outputs
   // expected to be visible during that same cycle.
   task automatic step(input int sel, input logic [31:0] r, input logic [31:0] s,
                       input logic [31:0] v, input logic [31:0] k, input logic [31:0] rp,
                       input logic [31:0] im, input logic [31:0] ix, input logic [31:0] rg,
                       input logic [31:0] push, input logic [31:0] epc,
                       input logic [31:0] erdy, input logic [31:0] emis);
      exp_t e;
      @(posedge clk);
      #1;
      e = '{pc: epc, rdy: erdy[0], mis: emis[0]};
      if (sel == 1) begin
         rst1 = r[0]; stall1 = s[0]; rv1 = v[0]; kind1 = k[1:0];
         rpc1 = rp; imm1 = im[15:0]; idx1 = ix[25:0]; rreg1 = rg;
         if (push[0]) q1.push_back(e);
      end else begin
         rst0 = r[0]; stall0 = s[0]; rv0 = v[0]; kind0 = k[1:0];
         rpc0 = rp; imm0 = im[15:0]; idx0 = ix[25:0]; rreg0 = rg;
         if (push[0]) q0.push_back(e);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (pcv1 === 1'b1) begin
         if (q1.size() == 0) begin
            chk("ds1_unexpected_valid_pc", pc1, 32'hxxxx_xxxx);
         end else begin
            e = q1.pop_front();
            chk("ds1_pc", pc1, e.pc);
            chk("ds1_redir_ready", 32'(rdy1), 32'(e.rdy));
            chk("ds1_misalign_err", 32'(mis1), 32'(e.mis));
         end
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (pcv0 === 1'b1) begin
         if (q0.size() == 0) begin
            chk("ds0_unexpected_valid_pc", pc0, 32'hxxxx_xxxx);
         end else begin
            e = q0.pop_front();
            chk("ds0_pc", pc0, e.pc);
            chk("ds0_redir_ready", 32'(rdy0), 32'(e.rdy));
            chk("ds0_misalign_err", 32'(mis0), 32'(e.mis));
         end
      end
   end

   initial begin
      // One delay slot: boot, branch, misaligned/aligned jump-register, stalled branch, reset in PEND
      step(1, 1,0,0,0,0,0,0,0, 0, 0,0,0);
      step(1, 0,0,0,0,0,0,0,0, 0, 0,0,0);
      chk("ds1_reset_pc", pc1, RPC);
      chk("ds1_reset_pc_valid", 32'(pcv1), 0);
      chk("ds1_reset_ready", 32'(rdy1), 0);
      chk("ds1_reset_misalign", 32'(mis1), 0);
      step(1, 0,0,0,0,0,0,0,0, 1, 32'h0040_0000,1,0);
      step(1, 0,0,0,0,0,0,0,0, 1, 32'h0040_0004,1,0);
      step(1, 0,0,0,0,0,0,0,0, 1, 32'h0040_0008,1,0);
      step(1, 0,0,0,0,0,0,0,0, 1, 32'h0040_000C,1,0);
      step(1, 0,0,1,K_BR,32'h0040_0010,32'hFFFC,0,0, 1, 32'h0040_0010,1,0);
      step(1, 0,0,0,0,0,0,0,0, 1, 32'h0040_0014,0,0);
      step(1, 0,0,1,K_JR,0,0,0,32'h0040_0002, 1, 32'h0040_0004,1,0);
      step(1, 0,0,1,K_JR,0,0,0,32'h0040_0020, 1, 32'h0040_0008,1,1);
      step(1, 0,0,0,0,0,0,0,0, 1, 32'h0040_000C,0,0);
      step(1, 0,1,1,K_BR,32'h0040_0020,32'h0010,0,0, 1, 32'h0040_0020,1,0);
      step(1, 0,1,1,K_J,32'h0040_0020,0,32'h03FF_FFFF,0, 1, 32'h0040_0020,0,0);
      for (int i = 0; i < 3; i++) step(1, 0,1,0,0,0,0,0,0, 1, 32'h0040_0020,0,0);
      step(1, 0,0,0,0,0,0,0,0, 1, 32'h0040_0020,0,0);
      step(1, 0,0,0,0,0,0,0,0, 1, 32'h0040_0024,0,0);
      step(1, 0,0,0,0,0,0,0,0, 1, 32'h0040_0064,1,0);
      step(1, 0,1,1,K_BR,32'h0040_0068,32'h0100,0,0, 1, 32'h0040_0068,1,0);
      step(1, 1,1,0,0,0,0,0,0, 1, 32'h0040_0068,0,0);
      step(1, 0,0,0,0,0,0,0,0, 0, 0,0,0);
      chk("ds1_rst_in_pend_pc", pc1, RPC);
      chk("ds1_rst_in_pend_valid", 32'(pcv1), 0);
      chk("ds1_rst_in_pend_ready", 32'(rdy1), 0);
      step(1, 0,0,1,K_RSV,32'h0040_0000,32'h0040,0,0, 1, 32'h0040_0000,1,0);
      step(1, 0,0,0,0,0,0,0,0, 1, 32'h0040_0004,1,0);
      step(1, 1,0,0,0,0,0,0,0, 1, 32'h0040_0008,1,0);

      // No delay slot: jump, jump-register, wrap, max positive branch, stalled branch
      step(0, 0,0,0,0,0,0,0,0, 0, 0,0,0);
      chk("ds0_reset_pc_valid", 32'(pcv0), 0);
      chk("ds0_reset_ready", 32'(rdy0), 0);
      step(0, 0,0,1,K_J,32'h1000_0008,0,32'h0000_0040,0, 1, 32'h0040_0000,1,0);
      step(0, 0,0,1,K_JR,0,0,0,32'hFFFF_FFFC, 1, 32'h1000_0100,1,0);
      step(0, 0,0,0,0,0,0,0,0, 1, 32'hFFFF_FFFC,1,0);
      step(0, 0,0,1,K_BR,32'h0000_0000,32'h7FFF,0,0, 1, 32'h0000_0000,1,0);
      step(0, 0,1,1,K_BR,32'h0002_0000,32'h0004,0,0, 1, 32'h0002_0000,1,0);
      step(0, 0,1,0,0,0,0,0,0, 1, 32'h0002_0000,0,0);
      step(0, 0,0,0,0,0,0,0,0, 1, 32'h0002_0000,0,0);
      step(0, 0,0,0,0,0,0,0,0, 1, 32'h0002_0014,1,0);
      step(0, 0,0,0,0,0,0,0,0, 1, 32'h0002_0018,1,0);
      step(0, 1,0,0,0,0,0,0,0, 1, 32'h0002_001C,1,0);

      repeat (3) @(posedge clk);
      #1;
      chk("ds1_queue_drained", q1.size(), 0);
      chk("ds0_queue_drained", q0.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
